// File: rtl/postfix_eval.sv
// postfix_eval: postfix stack evaluator (add/sub/shift-add mul) with token handshake (tok_*), result pulse (result/result_valid), sticky ovf and err/err_code
module postfix_eval #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 8,
  localparam int MUL_CYC = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              tok_valid,
  input  logic              tok_is_op,
  input  logic [DATA_W-1:0] tok_data,
  input  logic              tok_last,
  output logic              tok_ready,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              ovf,
  output logic              err,
  output logic [1:0]        err_code
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MUL_CYC) + 1;
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] TWO = (AW+1)'(2);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CLAST = CW'(MUL_CYC - 1);
  typedef enum logic [2:0] {ACCEPT, EXEC, MUL, FINAL, ERR} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] stk [DEPTH];
  logic [AW:0] sp, sp_n;
  logic [DATA_W-1:0] a, b, a_mag, b_mag, sum, push_val, mplier;
  logic [1:0] op, ecode_n;
  logic last, take, sum_ovf, push, ovf_set, neg, prod_ovf, fin_ok;
  logic [CW-1:0] cnt;
  logic [2*DATA_W-1:0] pacc, pacc_n, mcand, prod;
  assign tok_ready = state == ACCEPT && !clr;
  assign err = state == ERR;
  assign take = tok_valid && tok_ready;
  assign fin_ok = state == FINAL && sp == ONE && !clr;
  assign sum = op[0] ? a - b : a + b;
  assign sum_ovf = (a[DATA_W-1] ^ sum[DATA_W-1]) & (op[0] ? a[DATA_W-1] ^ b[DATA_W-1] : ~(a[DATA_W-1] ^ b[DATA_W-1]));
  assign a_mag = a[DATA_W-1] ? -a : a;
  assign b_mag = b[DATA_W-1] ? -b : b;
  assign pacc_n = pacc + (mplier[0] ? mcand : '0);
  assign prod = neg ? -pacc_n : pacc_n;
  assign prod_ovf = !(&prod[2*DATA_W-1:DATA_W-1] || ~|prod[2*DATA_W-1:DATA_W-1]);
  always_comb begin
    state_n = state;
    sp_n = sp;
    push = 1'b0;
    push_val = tok_data;
    ovf_set = 1'b0;
    ecode_n = err_code;
    case (state)
      ACCEPT: if (take) begin
        if (!tok_is_op) begin
          if (sp == FULL) begin
            state_n = ERR;
            ecode_n = 2'b01;
          end else begin
            push = 1'b1;
            sp_n = sp + ONE;
            state_n = tok_last ? FINAL : ACCEPT;
          end
        end else if (sp < TWO) begin
          state_n = ERR;
          ecode_n = 2'b10;
        end else if (tok_data[1:0] == 2'b11) begin
          state_n = ERR;
          ecode_n = 2'b11;
        end else begin
          sp_n = sp - TWO;
          state_n = EXEC;
        end
      end
      EXEC: if (op == 2'b10) state_n = MUL;
      else begin
        push = 1'b1;
        push_val = sum;
        sp_n = sp + ONE;
        ovf_set = sum_ovf;
        state_n = last ? FINAL : ACCEPT;
      end
      MUL: if (cnt == CLAST) begin
        push = 1'b1;
        push_val = prod[DATA_W-1:0];
        sp_n = sp + ONE;
        ovf_set = prod_ovf;
        state_n = last ? FINAL : ACCEPT;
      end
      FINAL: if (sp == ONE) begin
        sp_n = '0;
        state_n = ACCEPT;
      end else begin
        state_n = ERR;
        ecode_n = sp == '0 ? 2'b10 : 2'b11;
      end
      ERR: state_n = ERR;
      default: state_n = ACCEPT;
    endcase
    if (clr) begin
      state_n = ACCEPT;
      sp_n = '0;
      push = 1'b0;
      ovf_set = 1'b0;
      ecode_n = 2'b00;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ACCEPT;
    else state <= state_n;
  always_ff @(posedge clk)
    if (push) stk[sp[AW-1:0]] <= push_val;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sp <= '0;
      a <= '0;
      b <= '0;
      op <= 2'b00;
      last <= 1'b0;
      cnt <= '0;
      pacc <= '0;
      mcand <= '0;
      mplier <= '0;
      neg <= 1'b0;
      result <= '0;
      result_valid <= 1'b0;
      ovf <= 1'b0;
      err_code <= 2'b00;
    end else begin
      sp <= sp_n;
      err_code <= ecode_n;
      ovf <= (clr || result_valid) ? 1'b0 : ovf | ovf_set;
      result_valid <= fin_ok;
      if (fin_ok) result <= stk[0];
      if (take && tok_is_op) begin
        b <= stk[AW'(sp - ONE)];
        a <= stk[AW'(sp - TWO)];
        op <= tok_data[1:0];
        last <= tok_last;
      end
      if (state == EXEC) begin
        cnt <= '0;
        pacc <= '0;
        mcand <= {{DATA_W{1'b0}}, b_mag};
        mplier <= a_mag;
        neg <= a[DATA_W-1] ^ b[DATA_W-1];
      end
      if (state == MUL) begin
        cnt <= cnt + 1'b1;
        pacc <= pacc_n;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
      end
      if (clr) cnt <= '0;
    end
endmodule

// File: tb/tb_postfix_eval.sv
// tb_postfix_eval: directed and random postfix expressions checked against a queue-based reference evaluator
module tb_postfix_eval;
  localparam int W = 16;
  localparam int D = 8;
  typedef struct packed {logic is_op; logic [W-1:0] data; logic last;} tok_t;
  logic clk = 1'b0, rst, clr, tok_valid, tok_is_op, tok_last;
  logic [W-1:0] tok_data, result;
  logic tok_ready, result_valid, ovf, err;
  logic [1:0] err_code;
  int checks = 0, passes = 0, fails = 0;
  tok_t tq[$];
  logic [W-1:0] obs_res;
  postfix_eval #(.DATA_W(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .clr(clr), .tok_valid(tok_valid), .tok_is_op(tok_is_op),
    .tok_data(tok_data), .tok_last(tok_last), .tok_ready(tok_ready), .result(result),
    .result_valid(result_valid), .ovf(ovf), .err(err), .err_code(err_code)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic tok_t num(input int v, input bit l);
    tok_t t;
    t.is_op = 1'b0;
    t.data = v[W-1:0];
    t.last = l;
    return t;
  endfunction
  function automatic tok_t opr(input int c, input bit l);
    tok_t t;
    t.is_op = 1'b1;
    t.data = W'(c);
    t.last = l;
    return t;
  endfunction
  function automatic longint wrap(input longint v);
    logic [W-1:0] t;
    t = v[W-1:0];
    return longint'($signed(t));
  endfunction
  task automatic push_num(input int v);
    tq.push_back(num(v, 1'b0));
  endtask
  task automatic push_op(input int c);
    tq.push_back(opr(c, 1'b0));
  endtask
  task automatic mark_last();
    tq[tq.size()-1].last = 1'b1;
  endtask
  task automatic model(output int stop, output bit is_err, output logic [1:0] code,
                       output logic [W-1:0] val, output bit ov);
    longint st[$];
    longint x, y, r, w;
    stop = tq.size() - 1;
    is_err = 0;
    code = 2'b00;
    val = '0;
    ov = 0;
    for (int i = 0; i < tq.size(); i++) begin
      if (!tq[i].is_op) begin
        if (st.size() == D) begin
          is_err = 1; code = 2'b01; stop = i; return;
        end
        st.push_back(longint'($signed(tq[i].data)));
      end else begin
        if (st.size() < 2) begin
          is_err = 1; code = 2'b10; stop = i; return;
        end
        if (tq[i].data[1:0] == 2'b11) begin
          is_err = 1; code = 2'b11; stop = i; return;
        end
        y = st.pop_back();
        x = st.pop_back();
        r = tq[i].data[1:0] == 2'b00 ? x + y : tq[i].data[1:0] == 2'b01 ? x - y : x * y;
        w = wrap(r);
        if (w != r) ov = 1;
        st.push_back(w);
      end
      if (tq[i].last) begin
        stop = i;
        if (st.size() == 1) begin
          w = st[0];
          val = w[W-1:0];
        end else begin
          is_err = 1;
          code = st.size() == 0 ? 2'b10 : 2'b11;
        end
        return;
      end
    end
  endtask
  task automatic send(input tok_t t);
    int n = 0;
    @(negedge clk);
    while (!tok_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!tok_ready) chk("send_ready_timeout", 32'(tok_ready), 32'd1);
    tok_valid = 1'b1;
    tok_is_op = t.is_op;
    tok_data = t.data;
    tok_last = t.last;
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
    tok_is_op = 1'b0;
    tok_last = 1'b0;
    tok_data = '0;
  endtask
  task automatic busy(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tok_ready) break;
      n++;
    end
  endtask
  task automatic wait_result(input string tag, input logic [W-1:0] exp_val, input bit exp_ov);
    bit got = 0;
    logic o = 1'b0, e = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (result_valid) begin
        got = 1;
        obs_res = result;
        o = ovf;
        e = err;
      end
    end
    chk({tag, "_rv_seen"}, 32'(got), 32'd1);
    chk({tag, "_result"}, 32'(obs_res), 32'(exp_val));
    chk({tag, "_ovf"}, 32'(o), 32'(exp_ov));
    chk({tag, "_err"}, 32'(e), 32'd0);
    @(negedge clk);
    chk({tag, "_rv_single"}, 32'(result_valid), 32'd0);
    chk({tag, "_ovf_clear"}, 32'(ovf), 32'd0);
  endtask
  task automatic run_expr(input string tag);
    int stop, n;
    bit is_err, ov;
    logic [1:0] code;
    logic [W-1:0] val;
    model(stop, is_err, code, val, ov);
    for (int i = 0; i <= stop; i++) send(tq[i]);
    if (is_err) begin
      n = 0;
      while (!err && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk({tag, "_err"}, 32'(err), 32'd1);
      chk({tag, "_code"}, 32'(err_code), 32'(code));
      chk({tag, "_ready_low"}, 32'(tok_ready), 32'd0);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      #1;
      chk({tag, "_clr_err"}, 32'(err), 32'd0);
      chk({tag, "_clr_code"}, 32'(err_code), 32'd0);
      chk({tag, "_clr_ready"}, 32'(tok_ready), 32'd1);
      chk({tag, "_clr_ovf"}, 32'(ovf), 32'd0);
    end else wait_result(tag, val, ov);
  endtask
  task automatic gen();
    int n, pushed = 0, depth = 0;
    tq.delete();
    n = int'($urandom_range(1, 6));
    while (pushed < n || depth > 1) begin
      if (pushed < n && (depth < 2 || $urandom_range(0, 1) == 1)) begin
        push_num($urandom_range(0, 3) == 0 ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 600)) - 300);
        pushed++;
        depth++;
      end else begin
        push_op($urandom_range(0, 7) == 0 ? 3 : int'($urandom_range(0, 2)));
        depth--;
      end
    end
    mark_last();
  endtask
  initial begin
    int n, cnt;
    logic [W-1:0] prev;
    clr = 1'b0;
    tok_valid = 1'b0;
    tok_is_op = 1'b0;
    tok_last = 1'b0;
    tok_data = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    rst = 1'b1;
    #1 chk("rst_ready", 32'(tok_ready), 32'd1);
    tq.delete();
    push_num(80); push_num(25); push_op(2); push_num(334); push_op(1);
    push_num(99); push_num(30); push_op(2); push_op(0); mark_last();
    run_expr("expr4636");
    chk("expr4636_lit", 32'(obs_res), 32'd4636);
    tq.delete();
    push_num(7); push_num(9); push_op(1); mark_last();
    run_expr("sub_neg");
    chk("sub_neg_lit", 32'(obs_res), 32'hFFFE);
    send(num(3, 0)); send(num(4, 0)); send(opr(2, 0));
    busy(n);
    chk("mul_busy", 32'(n), 32'd17);
    send(num(0, 0)); send(opr(0, 0));
    busy(n);
    chk("add_busy", 32'(n), 32'd1);
    send(num(0, 0)); send(opr(0, 1));
    wait_result("mul_timing", 16'd12, 1'b0);
    tq.delete();
    for (int i = 1; i <= 9; i++) push_num(i);
    mark_last();
    run_expr("push9");
    tq.delete();
    push_op(0); mark_last();
    run_expr("op_first");
    tq.delete();
    push_num(1); push_num(2); mark_last();
    run_expr("leftover");
    tq.delete();
    push_num(1); push_num(2); push_op(3); mark_last();
    run_expr("bad_op");
    tq.delete();
    push_num(300); push_num(300); push_op(2); mark_last();
    run_expr("mul_wrap");
    chk("mul_wrap_lit", 32'(obs_res), 32'h5F90);
    tq.delete();
    push_num(32767); push_num(1); push_op(0); mark_last();
    run_expr("add_wrap");
    chk("add_wrap_lit", 32'(obs_res), 32'h8000);
    tq.delete();
    push_num(-32768); push_num(-1); push_op(2); mark_last();
    run_expr("mul_minmag");
    send(num(5, 0)); send(num(6, 0)); send(opr(2, 1));
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_rv", 32'(result_valid), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_code", 32'(err_code), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (result_valid) cnt++;
    end
    chk("midrst_no_rv", 32'(cnt), 32'd0);
    chk("midrst_ready", 32'(tok_ready), 32'd1);
    tq.delete();
    push_num(2); push_num(3); push_op(0); mark_last();
    run_expr("after_rst");
    chk("after_rst_lit", 32'(obs_res), 32'd5);
    tq.delete();
    push_num(9); push_num(4); push_op(1); mark_last();
    run_expr("pre_clr");
    prev = result;
    send(num(5, 0)); send(num(6, 0)); send(opr(2, 1));
    repeat (4) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (result_valid) cnt++;
    end
    chk("clr_no_rv", 32'(cnt), 32'd0);
    chk("clr_keep_result", 32'(result), 32'(prev));
    chk("clr_ready", 32'(tok_ready), 32'd1);
    tq.delete();
    push_num(2); push_num(3); push_op(0); mark_last();
    run_expr("after_clr");
    chk("after_clr_lit", 32'(obs_res), 32'd5);
    for (int k = 0; k < 40; k++) begin
      gen();
      run_expr($sformatf("rnd%0d", k));
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/postfix_eval.md
POSTFIX_EVAL -- requirements
Module: postfix_eval

Interface
REQ-001 Parameter DATA_W, default 16, operand/result width in bits, two's complement.
REQ-002 Parameter DEPTH, default 8, operand stack entries (power of 2, >= 2).
REQ-003 Parameter MUL_CYC, fixed at DATA_W, cycles per shift-add multiply step sequence.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous reset, active-low (0 = reset).
REQ-006 clr  input  1  synchronous clear of stack, error and pending token state.
REQ-007 tok_valid  input  1  postfix token present from the infix-to-postfix converter.
REQ-008 tok_is_op  input  1  1 = operator token, 0 = operand token.
REQ-009 tok_data  input  DATA_W  operand value; when tok_is_op=1, bits [1:0] = op (00 add, 01 sub, 10 mul, 11 reserved).
REQ-010 tok_last  input  1  marks the final token of an expression (the "=" key).
REQ-011 tok_ready  output  1  token accepted on a cycle where tok_valid & tok_ready.
REQ-012 result  output  DATA_W  last evaluated expression value, held until the next result.
REQ-013 result_valid  output  1  one-cycle pulse when result updates.
REQ-014 ovf  output  1  sticky: an arithmetic result wrapped in the current expression.
REQ-015 err  output  1  high in ERR state.
REQ-016 err_code  output  2  01 stack overflow, 10 stack underflow, 11 bad op/leftover operands; 00 none.

Function
REQ-017 FSM states SHALL be ACCEPT, EXEC, MUL, FINAL, ERR; tok_ready SHALL be 1 only in ACCEPT.
REQ-018 ACCEPT, operand accepted: push tok_data the same edge, sp+1; if sp==DEPTH before push -> ERR, err_code=01, no write.
REQ-019 ACCEPT, operator accepted: if sp<2 -> ERR, err_code=10; if op=11 -> ERR, err_code=11; else latch b=stack[sp-1], a=stack[sp-2], sp-2, op, tok_last -> EXEC.
REQ-020 EXEC, add/sub: compute a+b or a-b truncated to DATA_W, push it, set ovf if signed overflow; -> FINAL if latched last else ACCEPT.
REQ-021 EXEC, mul: -> MUL; MUL runs exactly MUL_CYC cycles of shift-add on sign-handled magnitudes, then pushes low DATA_W bits of product; ovf set if product does not fit signed DATA_W.
REQ-022 Latency: operator accepted in cycle 0 -> add/sub result written end of cycle 1, tok_ready high cycle 2; mul result written end of cycle 1+MUL_CYC, tok_ready high cycle 2+MUL_CYC.
REQ-023 Operand with tok_last=1: push, then -> FINAL next cycle.
REQ-024 FINAL: if sp==1, result<=stack[0], result_valid=1 next cycle, sp<=0, ovf cleared after the pulse, -> ACCEPT; else -> ERR, err_code=11 (sp==0 -> 10).
REQ-025 ERR: tok_ready=0, stack frozen, err/err_code held until clr or rst; clr -> ACCEPT, sp=0, ovf=0, err_code=00.
REQ-026 clr in any state SHALL abort a running EXEC/MUL with no push and no result_valid; result SHALL keep its previous value.
REQ-027 tok_valid with tok_ready=0 SHALL be ignored (no implicit buffering); upstream holds the token.

Reset
REQ-028 rst=0 SHALL force immediately: state ACCEPT, sp=0, result=0, result_valid=0, ovf=0, err=0, err_code=00, MUL counter=0; tok_ready=1 after release.
REQ-029 Reset mid-MUL SHALL discard the partial product; first token after release is treated as start of a new expression.

Verification
REQ-030 Tokens 80 25 * 334 - 99 30 * + (last on +) -> result=4636, result_valid one pulse, ovf=0, err=0.
REQ-031 Tokens 7 9 - (last) -> result=-2 (0xFFFE at DATA_W=16); mul timing: 3 4 * -> tok_ready low exactly 1+MUL_CYC cycles, result 12.
REQ-032 Push 9 operands with DEPTH=8 -> ERR, err_code=01 on 9th accept, tok_ready=0; clr -> tok_ready=1, err=0.
REQ-033 Token + as first token -> err_code=10; tokens 1 2 (last on 2) -> err_code=11.
REQ-034 300 300 * (last) at DATA_W=16 -> result=0x5F90 (90000 mod 65536), ovf=1 with result_valid; 32767 1 + -> -32768, ovf=1.
REQ-035 rst asserted during MUL of 5 6 * -> outputs at reset values, no result_valid; 2 3 + (last) after release -> result=5.
